// File: rtl/filter_3x3_stream.sv
// 3x3 neighbourhood filter (box, Gaussian, centre, max) over a column stream, with a credit-protected FWFT output FIFO.
// Define BOX_ROUND_EN for round-to-nearest box and Gaussian results; truncating otherwise.
module filter_3x3_stream #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    input  logic              i_sol,
    input  logic [DATA_W-1:0] i_pixel_1,
    input  logic [DATA_W-1:0] i_pixel_2,
    input  logic [DATA_W-1:0] i_pixel_3,
    input  logic              i_pixel_valid,
    output logic              o_pixel_ack,
    output logic              o_pixel_valid,
    input  logic              i_pixel_ack,
    output logic [DATA_W-1:0] o_pixel,
    output logic [LVL_W-1:0]  o_fifo_level
);

    localparam int IW = DATA_W + 4;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = LVL_W + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef BOX_ROUND_EN
    localparam logic [IW-1:0] BOX_BIAS   = IW'(4);
    localparam logic [IW-1:0] GAUSS_BIAS = IW'(8);
`else
    localparam logic [IW-1:0] BOX_BIAS   = '0;
    localparam logic [IW-1:0] GAUSS_BIAS = '0;
`endif

    typedef enum logic [1:0] {
        MODE_BOX    = 2'b00,
        MODE_GAUSS  = 2'b01,
        MODE_CENTRE = 2'b10,
        MODE_MAX    = 2'b11
    } mode_e;

    // Separable reduction: the same combine rule is used over rows, then over columns.
    function automatic logic [IW-1:0] reduce3(input mode_e m, input logic [IW-1:0] a,
                                              input logic [IW-1:0] b, input logic [IW-1:0] c);
        logic [IW-1:0] r;
        case (m)
            MODE_BOX:    r = a + b + c;
            MODE_GAUSS:  r = a + (b << 1) + c;
            MODE_CENTRE: r = b;
            default: begin
                r = (a > b) ? a : b;
                r = (r > c) ? r : c;
            end
        endcase
        return r;
    endfunction

    // Window: index 0 = c0 (newest), 2 = c2 (oldest); row index 0..2 = top..bottom.
    logic [DATA_W-1:0] win_q [3][3];
    logic [DATA_W-1:0] win_d [3][3];
    logic [1:0]        fill_q, fill_d;
    mode_e             mode_q, mode_d;
    logic              v1_q, v1_d;
    logic              ack_en_q, ack_en_d;

    logic [IW-1:0]     col_q [3];
    logic [IW-1:0]     col_d [3];
    mode_e             m2_q, m2_d;
    logic              v2_q, v2_d;

    logic [IW-1:0]     tot_q, tot_d;
    mode_e             m3_q, m3_d;
    logic              v3_q, v3_d;

    logic [IW-1:0]     quot;
    logic [DATA_W-1:0] res_q, res_d;
    logic              v4_q, v4_d;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic              xfer, fifo_wr, fifo_rd, fifo_empty;
    logic [CW-1:0]     credit_sum;

    // Every token still in the pipeline holds a reserved FIFO slot, so writes never need backpressure.
    assign credit_sum  = CW'(level_q) + CW'(v1_q) + CW'(v2_q) + CW'(v3_q) + CW'(v4_q);
    assign o_pixel_ack = ack_en_q & (credit_sum < DEPTH_C);
    assign xfer        = i_pixel_valid & o_pixel_ack;

    always_comb begin
        win_d    = win_q;
        fill_d   = fill_q;
        mode_d   = mode_q;
        v1_d     = 1'b0;
        ack_en_d = 1'b1;
        if (xfer) begin
            win_d[2]    = win_q[1];
            win_d[1]    = win_q[0];
            win_d[0][0] = i_pixel_1;
            win_d[0][1] = i_pixel_2;
            win_d[0][2] = i_pixel_3;
            if (i_sol) begin
                fill_d = 2'd1;
                mode_d = mode_e'(i_mode);
            end else if (fill_q != 2'd3) begin
                fill_d = fill_q + 2'd1;
            end
            v1_d = (fill_d == 2'd3);
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            col_d[c] = reduce3(mode_q, IW'(win_q[c][0]), IW'(win_q[c][1]), IW'(win_q[c][2]));
        end
        m2_d = mode_q;
        v2_d = v1_q;
        tot_d = reduce3(m2_q, col_q[2], col_q[1], col_q[0]);
        m3_d  = m2_q;
        v3_d  = v2_q;
    end

    always_comb begin
        case (m3_q)
            MODE_BOX:   quot = (tot_q + BOX_BIAS) / IW'(9);
            MODE_GAUSS: quot = (tot_q + GAUSS_BIAS) >> 4;
            default:    quot = tot_q;
        endcase
        res_d = DATA_W'(quot);
        v4_d  = v3_q;
    end

    assign fifo_empty    = (level_q == '0);
    assign o_pixel_valid = ~fifo_empty;
    assign o_pixel       = fifo_empty ? '0 : mem_q[rp_q];
    assign o_fifo_level  = level_q;
    assign fifo_wr       = v4_q;
    assign fifo_rd       = o_pixel_valid & i_pixel_ack;

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        level_d = level_q;
        if (fifo_wr) begin
            mem_d[wp_q] = res_q;
            wp_d        = wp_q + AW'(1);
        end
        if (fifo_rd) begin
            rp_d = rp_q + AW'(1);
        end
        case ({fifo_wr, fifo_rd})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned c = 0; c < 3; c++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win_q[c][r] <= '0;
                end
                col_q[c] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            fill_q   <= '0;
            mode_q   <= MODE_BOX;
            v1_q     <= 1'b0;
            ack_en_q <= 1'b0;
            m2_q     <= MODE_BOX;
            v2_q     <= 1'b0;
            tot_q    <= '0;
            m3_q     <= MODE_BOX;
            v3_q     <= 1'b0;
            res_q    <= '0;
            v4_q     <= 1'b0;
            wp_q     <= '0;
            rp_q     <= '0;
            level_q  <= '0;
        end else begin
            win_q    <= win_d;
            col_q    <= col_d;
            mem_q    <= mem_d;
            fill_q   <= fill_d;
            mode_q   <= mode_d;
            v1_q     <= v1_d;
            ack_en_q <= ack_en_d;
            m2_q     <= m2_d;
            v2_q     <= v2_d;
            tot_q    <= tot_d;
            m3_q     <= m3_d;
            v3_q     <= v3_d;
            res_q    <= res_d;
            v4_q     <= v4_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            level_q  <= level_d;
        end
    end

endmodule
